// File: rtl/clk_disp_drv.sv
// Display driver for the alarm-clock core: per-frame time snapshot, iterative BCD conversion,
// 4-digit multiplexed 7-segment scan, and AM/PM and alarm LEDs. Optional macro: HOUR_ZERO_BLANK_EN.
module clk_disp_drv #(
  parameter int unsigned SCAN_DIV  = 1000,
  parameter int unsigned BLINK_DIV = 250000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       AM_PM,
  input  logic       Alarm,
  input  logic [5:0] Secs_C,
  input  logic [5:0] Mins_C,
  input  logic [3:0] Hours_C,
  input  logic       DispMode,
  output logic [6:0] Seg,
  output logic [3:0] Dig,
  output logic       Dp,
  output logic       AmPmLed,
  output logic       AlarmLed
);

  localparam int unsigned SW = $clog2(SCAN_DIV);
  localparam int unsigned BW = $clog2(BLINK_DIV + 1);
  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [6:0] BLANK = 7'h7F;
  localparam logic [6:0] DASH  = 7'b0111111;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CONV_L, S_CONV_R, S_COMMIT} state_t;

  state_t          state, state_nx;
  logic [SW-1:0]   scan_cnt;
  logic [1:0]      idx;
  logic            frame_start;
  logic [BW-1:0]   blink_cnt;
  logic            alarm_q;

  logic            snap_ampm, snap_mode;
  logic [5:0]      snap_sec, snap_min;
  logic [3:0]      snap_hr;
  logic [5:0]      val;
  logic [2:0]      tens;
  logic [2:0]      l_tens;
  logic [3:0]      l_units;
  logic            l_dash, r_dash;
  logic [6:0]      disp [4];
  logic            colon_n;

  logic            l_dash_c, r_dash_c;
  logic [5:0]      l_val_c, r_val_c, r_raw;
  logic [6:0]      lt_c, lu_c, rt_c, ru_c;

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'd0:    glyph = 7'h40;
      4'd1:    glyph = 7'h79;
      4'd2:    glyph = 7'h24;
      4'd3:    glyph = 7'h30;
      4'd4:    glyph = 7'h19;
      4'd5:    glyph = 7'h12;
      4'd6:    glyph = 7'h02;
      4'd7:    glyph = 7'h78;
      4'd8:    glyph = 7'h00;
      4'd9:    glyph = 7'h10;
      default: glyph = BLANK;
    endcase
  endfunction

  assign frame_start = (scan_cnt == SCAN_LAST) && (idx == 2'd3);

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      scan_cnt <= '0;
      idx      <= '0;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt <= '0;
      idx      <= idx + 2'd1;
    end else begin
      scan_cnt <= scan_cnt + SW'(1);
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (frame_start) state_nx = S_LOAD;
      S_LOAD:   state_nx = S_CONV_L;
      S_CONV_L: if (val < 6'd10) state_nx = S_CONV_R;
      S_CONV_R: if (val < 6'd10) state_nx = S_COMMIT;
      S_COMMIT: state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // Out-of-range fields load 0 so the conversion stays short; the dash flag overrides the digits.
  always_comb begin
    l_dash_c = 1'b0;
    l_val_c  = '0;
    r_raw    = snap_mode ? snap_sec : snap_min;
    if (snap_mode) begin
      l_dash_c = snap_min > 6'd59;
      l_val_c  = l_dash_c ? 6'd0 : snap_min;
    end else begin
      l_dash_c = snap_hr > 4'd12;
      l_val_c  = l_dash_c ? 6'd0 : ((snap_hr == 4'd0) ? 6'd12 : {2'b00, snap_hr});
    end
    r_dash_c = r_raw > 6'd59;
    r_val_c  = r_dash_c ? 6'd0 : r_raw;
  end

  always_comb begin
`ifdef HOUR_ZERO_BLANK_EN
    lt_c = l_dash ? DASH : ((!snap_mode && l_tens == 3'd0) ? BLANK : glyph({1'b0, l_tens}));
`else
    lt_c = l_dash ? DASH : glyph({1'b0, l_tens});
`endif
    lu_c = l_dash ? DASH : glyph(l_units);
    rt_c = r_dash ? DASH : glyph({1'b0, tens});
    ru_c = r_dash ? DASH : glyph(val[3:0]);
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      snap_ampm <= 1'b0;
      snap_mode <= 1'b0;
      snap_sec  <= '0;
      snap_min  <= '0;
      snap_hr   <= '0;
      val       <= '0;
      tens      <= '0;
      l_tens    <= '0;
      l_units   <= '0;
      l_dash    <= 1'b0;
      r_dash    <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) disp[i] <= BLANK;
      colon_n   <= 1'b1;
      AmPmLed   <= 1'b0;
    end else begin
      if (frame_start) begin
        snap_ampm <= AM_PM;
        snap_mode <= DispMode;
        snap_sec  <= Secs_C;
        snap_min  <= Mins_C;
        snap_hr   <= Hours_C;
      end
      case (state)
        S_LOAD: begin
          tens   <= '0;
          val    <= l_val_c;
          l_dash <= l_dash_c;
        end
        S_CONV_L: begin
          if (val >= 6'd10) begin
            val  <= val - 6'd10;
            tens <= tens + 3'd1;
          end else begin
            l_tens  <= tens;
            l_units <= val[3:0];
            tens    <= '0;
            val     <= r_val_c;
            r_dash  <= r_dash_c;
          end
        end
        S_CONV_R: begin
          if (val >= 6'd10) begin
            val  <= val - 6'd10;
            tens <= tens + 3'd1;
          end
        end
        S_COMMIT: begin
          disp[3] <= lt_c;
          disp[2] <= lu_c;
          disp[1] <= rt_c;
          disp[0] <= ru_c;
          colon_n <= snap_sec[0];
          AmPmLed <= snap_ampm;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      Seg <= BLANK;
      Dig <= 4'hF;
      Dp  <= 1'b1;
    end else begin
      Seg <= disp[idx];
      Dig <= ~(4'b0001 << idx);
      Dp  <= (idx == 2'd2) ? colon_n : 1'b1;
    end
  end

  // A rising edge of Alarm lights the LED at once; afterwards it toggles on each counter wrap.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      alarm_q   <= 1'b0;
      blink_cnt <= '0;
      AlarmLed  <= 1'b0;
    end else begin
      alarm_q <= Alarm;
      if (!Alarm) begin
        AlarmLed  <= 1'b0;
        blink_cnt <= '0;
      end else if (!alarm_q) begin
        AlarmLed  <= 1'b1;
        blink_cnt <= '0;
      end else if (blink_cnt == BLINK_LAST) begin
        blink_cnt <= '0;
        AlarmLed  <= ~AlarmLed;
      end else begin
        blink_cnt <= blink_cnt + BW'(1);
      end
    end
  end

endmodule

// File: tb/tb_clk_disp_drv.sv
// Self-checking bench for clk_disp_drv: scan frames compared against a digit-level reference model,
// plus reset, mid-frame input change, range dashes, hour blanking and alarm flashing.
module tb_clk_disp_drv;

  localparam int unsigned SD = 20;
  localparam int unsigned BD = 24;
  localparam logic [6:0] BLANK = 7'h7F;
  localparam logic [6:0] DASH  = 7'b0111111;

  logic       Clock = 1'b0;
  logic       Reset, AM_PM, Alarm, DispMode;
  logic [5:0] Secs_C, Mins_C;
  logic [3:0] Hours_C;
  logic [6:0] Seg;
  logic [3:0] Dig;
  logic       Dp, AmPmLed, AlarmLed;

  int n_cmp = 0;
  int n_bad = 0;
  bit in_sync = 1'b0;
  logic [6:0] gly [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  clk_disp_drv #(.SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
    .Clock(Clock), .Reset(Reset), .AM_PM(AM_PM), .Alarm(Alarm),
    .Secs_C(Secs_C), .Mins_C(Mins_C), .Hours_C(Hours_C), .DispMode(DispMode),
    .Seg(Seg), .Dig(Dig), .Dp(Dp), .AmPmLed(AmPmLed), .AlarmLed(AlarmLed)
  );

  always #5 Clock = ~Clock;

  // Expected glyphs {digit3, digit2, digit1, digit0} straight from the display rules.
  function automatic logic [3:0][6:0] model(input int h, input int m, input int s, input bit mode);
    logic [3:0][6:0] d;
    int lv, r;
    if ((!mode && h > 12) || (mode && m > 59)) begin
      d[3] = DASH;
      d[2] = DASH;
    end else begin
      lv = mode ? m : ((h == 0) ? 12 : h);
      d[3] = gly[lv / 10];
      d[2] = gly[lv % 10];
`ifdef HOUR_ZERO_BLANK_EN
      if (!mode && lv < 10) d[3] = BLANK;
`endif
    end
    r = mode ? s : m;
    if (r > 59) begin
      d[1] = DASH;
      d[0] = DASH;
    end else begin
      d[1] = gly[r / 10];
      d[0] = gly[r % 10];
    end
    return d;
  endfunction

  task automatic wait_frame(output bit tmo);
    logic [3:0] prev;
    prev = Dig;
    tmo  = 1'b1;
    for (int i = 0; i < 6 * SD; i++) begin
      @(negedge Clock);
      if (Dig == 4'b1110 && prev != 4'b1110) begin
        tmo = 1'b0;
        break;
      end
      prev = Dig;
    end
  endtask

  // Applies inputs, waits for a frame that snapshotted them, and samples each slot near its end.
  task automatic capture_frame(input int h, input int m, input int s, input bit mode, input bit ampm,
                               input bit chg, input int ns,
                               output logic [3:0][6:0] segs, output logic [3:0][3:0] digs,
                               output logic [3:0] dps, output logic ap, output bit tmo);
    bit t1;
    t1 = 1'b0;
    Hours_C = 4'(h); Mins_C = 6'(m); Secs_C = 6'(s); DispMode = mode; AM_PM = ampm;
    if (!in_sync) wait_frame(t1);
    wait_frame(tmo);
    tmo = tmo | t1;
    if (chg) Secs_C = 6'(ns);
    for (int k = 0; k < 4; k++) begin
      repeat ((k == 0) ? SD - 2 : SD) @(negedge Clock);
      segs[k] = Seg;
      digs[k] = Dig;
      dps[k]  = Dp;
      if (k == 0) ap = AmPmLed;
    end
    in_sync = 1'b1;
  endtask

  task automatic test_reset;
    logic [3:0][6:0] segs, exp;
    logic [3:0][3:0] digs;
    logic [3:0] dps, ed;
    logic ap;
    bit tmo;
    Reset = 1'b0;
    AM_PM = 1'($urandom); Alarm = 1'b1; DispMode = 1'($urandom);
    Secs_C = 6'($urandom); Mins_C = 6'($urandom); Hours_C = 4'($urandom);
    repeat (4) @(negedge Clock);
    n_cmp++; if (Seg !== 7'h7F) begin n_bad++; $display("FAIL reset_seg got %h exp 7f", Seg); end
    n_cmp++; if (Dig !== 4'hF) begin n_bad++; $display("FAIL reset_dig got %h exp f", Dig); end
    n_cmp++; if (Dp !== 1'b1) begin n_bad++; $display("FAIL reset_dp got %b exp 1", Dp); end
    n_cmp++; if (AmPmLed !== 1'b0) begin n_bad++; $display("FAIL reset_ampm got %b exp 0", AmPmLed); end
    n_cmp++; if (AlarmLed !== 1'b0) begin n_bad++; $display("FAIL reset_alarm got %b exp 0", AlarmLed); end
    Alarm = 1'b0;
    @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    n_cmp++; if (Seg !== BLANK || Dig !== 4'b1110) begin
      n_bad++; $display("FAIL post_reset_blank got seg %h dig %h exp 7f e", Seg, Dig);
    end
    exp = {7'h79, 7'h24, 7'h40, 7'h40};
    in_sync = 1'b0;
    for (int f = 0; f < 2; f++) begin
      capture_frame(0, 0, 0, 1'b0, 1'b1, 1'b0, 0, segs, digs, dps, ap, tmo);
      n_cmp++; if (tmo) begin n_bad++; $display("FAIL zero_frame timeout got none exp frame"); end
      for (int k = 0; k < 4; k++) begin
        ed = 4'b0001 << k; ed = ~ed;
        n_cmp++; if (segs[k] !== exp[k]) begin n_bad++; $display("FAIL zero_seg%0d got %h exp %h", k, segs[k], exp[k]); end
        n_cmp++; if (digs[k] !== ed) begin n_bad++; $display("FAIL zero_dig%0d got %h exp %h", k, digs[k], ed); end
        n_cmp++; if (dps[k] !== (k != 2)) begin n_bad++; $display("FAIL zero_dp%0d got %b exp %b", k, dps[k], k != 2); end
      end
      n_cmp++; if (ap !== 1'b1) begin n_bad++; $display("FAIL zero_ampm got %b exp 1", ap); end
    end
  endtask

  task automatic test_midframe;
    logic [3:0][6:0] segs, exp;
    logic [3:0][3:0] digs;
    logic [3:0] dps;
    logic ap;
    bit tmo;
    int sv;
    for (int f = 0; f < 2; f++) begin
      sv = (f == 0) ? 58 : 59;
      capture_frame(11, 59, sv, 1'b1, 1'b0, f == 0, 59, segs, digs, dps, ap, tmo);
      exp = model(11, 59, sv, 1'b1);
      n_cmp++; if (tmo) begin n_bad++; $display("FAIL midframe timeout got none exp frame"); end
      for (int k = 0; k < 4; k++) begin
        n_cmp++; if (segs[k] !== exp[k]) begin n_bad++; $display("FAIL midframe%0d_seg%0d got %h exp %h", f, k, segs[k], exp[k]); end
        n_cmp++; if (dps[k] !== ((k == 2) ? 1'(sv % 2) : 1'b1)) begin
          n_bad++; $display("FAIL midframe%0d_dp%0d got %b", f, k, dps[k]);
        end
      end
      n_cmp++; if (ap !== 1'b0) begin n_bad++; $display("FAIL midframe_ampm got %b exp 0", ap); end
    end
  endtask

  task automatic test_range_and_blank;
    logic [3:0][6:0] segs, exp;
    logic [3:0][3:0] digs;
    logic [3:0] dps;
    logic ap;
    bit tmo;
    int th [5] = '{13, 13, 9, 15, 5};
    int tm [5] = '{7, 60, 5, 63, 60};
    int ts [5] = '{20, 33, 0, 12, 61};
    bit tmd [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int t = 0; t < 5; t++) begin
      capture_frame(th[t], tm[t], ts[t], tmd[t], 1'b1, 1'b0, 0, segs, digs, dps, ap, tmo);
      exp = model(th[t], tm[t], ts[t], tmd[t]);
      n_cmp++; if (tmo) begin n_bad++; $display("FAIL range%0d timeout got none exp frame", t); end
      for (int k = 0; k < 4; k++) begin
        n_cmp++; if (segs[k] !== exp[k]) begin n_bad++; $display("FAIL range%0d_seg%0d got %h exp %h", t, k, segs[k], exp[k]); end
      end
    end
  endtask

  task automatic test_random;
    logic [3:0][6:0] segs, exp;
    logic [3:0][3:0] digs;
    logic [3:0] dps, ed;
    logic ap;
    bit tmo, md, apm;
    int h, m, s;
    for (int f = 0; f < 14; f++) begin
      h = int'($urandom_range(15)); m = int'($urandom_range(63)); s = int'($urandom_range(63));
      md = 1'($urandom); apm = 1'($urandom);
      capture_frame(h, m, s, md, apm, 1'b0, 0, segs, digs, dps, ap, tmo);
      exp = model(h, m, s, md);
      n_cmp++; if (tmo) begin n_bad++; $display("FAIL rand%0d timeout got none exp frame", f); end
      for (int k = 0; k < 4; k++) begin
        ed = 4'b0001 << k; ed = ~ed;
        n_cmp++; if (segs[k] !== exp[k]) begin
          n_bad++; $display("FAIL rand%0d_seg%0d h=%0d m=%0d s=%0d md=%0d got %h exp %h", f, k, h, m, s, md, segs[k], exp[k]);
        end
        n_cmp++; if (digs[k] !== ed) begin n_bad++; $display("FAIL rand%0d_dig%0d got %h exp %h", f, k, digs[k], ed); end
        n_cmp++; if (dps[k] !== ((k == 2) ? 1'(s % 2) : 1'b1)) begin
          n_bad++; $display("FAIL rand%0d_dp%0d got %b s=%0d", f, k, dps[k], s);
        end
      end
      n_cmp++; if (ap !== apm) begin n_bad++; $display("FAIL rand%0d_ampm got %b exp %b", f, ap, apm); end
    end
  endtask

  task automatic test_alarm;
    logic e;
    for (int r = 0; r < 2; r++) begin
      @(negedge Clock);
      Alarm = 1'b1;
      @(posedge Clock); #1;
      n_cmp++; if (AlarmLed !== 1'b1) begin n_bad++; $display("FAIL alarm_rise%0d got %b exp 1", r, AlarmLed); end
      for (int i = 1; i <= 3 * int'(BD) + 2; i++) begin
        @(posedge Clock); #1;
        e = 1'b1 ^ 1'((i / int'(BD)) % 2);
        n_cmp++; if (AlarmLed !== e) begin n_bad++; $display("FAIL alarm_blink%0d_c%0d got %b exp %b", r, i, AlarmLed, e); end
      end
      @(negedge Clock);
      Alarm = 1'b0;
      @(posedge Clock); #1;
      n_cmp++; if (AlarmLed !== 1'b0) begin n_bad++; $display("FAIL alarm_off%0d got %b exp 0", r, AlarmLed); end
      repeat (int'($urandom_range(5, 1))) @(negedge Clock);
    end
    in_sync = 1'b0;
  endtask

  task automatic test_reset_midconv;
    logic [3:0][6:0] segs, exp;
    logic [3:0][3:0] digs;
    logic [3:0] dps;
    logic ap;
    bit tmo, t1;
    Hours_C = 4'd7; Mins_C = 6'd42; Secs_C = 6'd13; DispMode = 1'b0; AM_PM = 1'b1;
    wait_frame(t1);
    wait_frame(tmo);
    n_cmp++; if (tmo | t1) begin n_bad++; $display("FAIL midconv timeout got none exp frame"); end
    @(negedge Clock);
    Reset = 1'b0;
    #1;
    n_cmp++; if (Seg !== 7'h7F || Dig !== 4'hF || Dp !== 1'b1) begin
      n_bad++; $display("FAIL midconv_reset got seg %h dig %h dp %b exp 7f f 1", Seg, Dig, Dp);
    end
    n_cmp++; if (AmPmLed !== 1'b0 || AlarmLed !== 1'b0) begin
      n_bad++; $display("FAIL midconv_leds got %b%b exp 00", AmPmLed, AlarmLed);
    end
    repeat (3) @(negedge Clock);
    Reset = 1'b1;
    repeat (SD) @(negedge Clock);
    n_cmp++; if (Seg !== BLANK) begin n_bad++; $display("FAIL midconv_partial got %h exp 7f", Seg); end
    in_sync = 1'b0;
    capture_frame(7, 42, 13, 1'b0, 1'b1, 1'b0, 0, segs, digs, dps, ap, tmo);
    exp = model(7, 42, 13, 1'b0);
    n_cmp++; if (tmo) begin n_bad++; $display("FAIL midconv_frame timeout got none exp frame"); end
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (segs[k] !== exp[k]) begin n_bad++; $display("FAIL midconv_seg%0d got %h exp %h", k, segs[k], exp[k]); end
    end
    n_cmp++; if (ap !== 1'b1) begin n_bad++; $display("FAIL midconv_ampm got %b exp 1", ap); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_midframe();
    test_range_and_blank();
    test_random();
    test_alarm();
    test_reset_midconv();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
